// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader and the maxpooling stage that reads its image buffer.
package frame_loader_pkg;

    localparam int IMG_W        = 128;
    localparam int IMG_H        = 128;
    localparam int AW           = 13;
    localparam int BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {FILL, START, WAIT_HI, WAIT_LO} loader_state_t;

    // Word address of the pair holding pixel (row, col) in the default-sized frame.
    function automatic logic [AW-1:0] word_addr(input int unsigned row, input int unsigned col);
        return AW'(row * (IMG_W / 2) + col / 2);
    endfunction

endpackage

// File: rtl/frame_loader_pixel_pair_packer.sv
// Packs two consecutive pixels into one 16-bit buffer word; the write appears one cycle after the odd beat.
module pixel_pair_packer
    import frame_loader_pkg::*;
#(
    parameter int AW = frame_loader_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic          sof,
    input  logic          flush,
    input  logic [7:0]    data,
    input  logic [AW-1:0] addr,
    output logic          wen,
    output logic [15:0]   wdata,
    output logic [AW-1:0] waddr
);

    logic [7:0] pair_hi;
    logic       odd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pair_hi <= '0;
            odd     <= 1'b0;
            wen     <= 1'b0;
            wdata   <= '0;
            waddr   <= '0;
        end else begin
            wen <= 1'b0;
            if (flush) begin
                odd <= 1'b0;
            end else if (beat) begin
                // A sof beat always opens a new pair, dropping any half-filled one.
                if (sof || !odd) begin
                    pair_hi <= data;
                    odd     <= 1'b1;
                end else begin
                    wen   <= 1'b1;
                    wdata <= {pair_hi, data};
                    waddr <= addr;
                    odd   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Fills the shared image buffer with one frame, starts maxpooling with a ready pulse and
// holds off the next frame until maxpooling has raised and dropped busy.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int IMG_W        = frame_loader_pkg::IMG_W,
    parameter int IMG_H        = frame_loader_pkg::IMG_H,
    parameter int AW           = frame_loader_pkg::AW,
    parameter int BUSY_TIMEOUT = frame_loader_pkg::BUSY_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          pix_sof,
    input  logic [7:0]    pix_data,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [15:0]   mem_wdata,
    output logic          ready,
    input  logic          busy,
    output logic [7:0]    frame_cnt,
    output logic          sof_err,
    output logic [1:0]    state_dbg
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    loader_state_t state, state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_frame;
    logic [TW-1:0] to_cnt;
    logic          prev_fill;
    logic          pix_ready_d, ready_d;

    // Handshake: a pixel beat transfers on a rising edge where pix_valid && pix_ready; pix_valid
    // may be held across any number of pix_ready==0 cycles and the beat is taken once ready returns.
    logic          accept, beat, last_beat;
    logic [AW-1:0] pair_addr;

    assign accept    = pix_valid && pix_ready;
    assign beat      = accept && (pix_sof || in_frame);
    assign last_beat = accept && !pix_sof && in_frame &&
                       (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign pair_addr = AW'(row) * AW'(IMG_W / 2) + AW'(col >> 1);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) state <= FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (last_beat) state_next = START;
            START:   state_next = WAIT_HI;
            WAIT_HI: begin
                if (busy)                                state_next = WAIT_LO;
                else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) state_next = START;
            end
            WAIT_LO: if (!busy) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        pix_ready_d = (state_next == FILL);
        ready_d     = (state == START);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_ready <= 1'b0;
            ready     <= 1'b0;
        end else begin
            pix_ready <= pix_ready_d;
            ready     <= ready_d;
        end
    end

    // Only a START entered from FILL counts a frame; re-pulses after a busy timeout do not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
            to_cnt    <= '0;
            prev_fill <= 1'b0;
        end else begin
            prev_fill <= (state == FILL);
            if (state == START) begin
                to_cnt <= '0;
                if (prev_fill) frame_cnt <= frame_cnt + 8'd1;
            end else if (state == WAIT_HI && !busy) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row      <= '0;
            col      <= '0;
            in_frame <= 1'b0;
            sof_err  <= 1'b0;
        end else if (accept) begin
            if (pix_sof) begin
                sof_err  <= sof_err | in_frame;
                row      <= '0;
                col      <= CW'(1);
                in_frame <= 1'b1;
            end else if (in_frame) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    if (row == RW'(IMG_H - 1)) begin
                        row      <= '0;
                        in_frame <= 1'b0;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    pixel_pair_packer #(.AW(AW)) u_packer (
        .clk   (clk),
        .rst   (rst),
        .beat  (beat),
        .sof   (pix_sof),
        .flush (state != FILL),
        .data  (pix_data),
        .addr  (pair_addr),
        .wen   (mem_wen),
        .wdata (mem_wdata),
        .waddr (mem_waddr)
    );

endmodule
